// File: rtl/tag_memory_assoc.sv
// Set-associative cache tag array: per-way valid bits, hit compare, per-set
// round-robin victim pointer and a one-set-per-cycle invalidate-all walk.
module tag_memory_assoc #(
  parameter int SETS  = 256,
  parameter int WAYS  = 4,
  parameter int TAG_W = 20,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [WAY_W-1:0] req_way,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             resp_multi,
  output logic             resp_evict,
  output logic [TAG_W-1:0] resp_evict_tag
);

  localparam logic [1:0]       OP_LOOKUP = 2'b00;
  localparam logic [1:0]       OP_WRITE  = 2'b01;
  localparam logic [1:0]       OP_INVAL  = 2'b10;
  localparam logic [1:0]       OP_ALLOC  = 2'b11;
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;

  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid   [SETS];
  logic [WAY_W-1:0] rr_ptr  [SETS];

  logic             accept;
  logic [WAYS-1:0]  match;
  logic [3:0]       nmatch;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] rr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FLUSH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (flush_req) state_nxt = S_FLUSH;
      S_FLUSH: if (cnt == LAST_SET) state_nxt = S_IDLE;
      default: state_nxt = S_FLUSH;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    flush_busy = (state == S_FLUSH);
  end

  // Walk counter wraps back to 0 on the final set, ready for the next walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == S_FLUSH)  cnt <= cnt + 1'b1;
    else                        cnt <= '0;
  end

  // A flush request wins over a request offered in the same cycle.
  assign accept = req_valid && req_ready && !flush_req;

  always_comb begin
    match    = '0;
    nmatch   = '0;
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[req_index][w] && (tag_mem[req_index][w] == req_tag);
      nmatch   = nmatch + 4'(match[w]);
      if (match[w] && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[req_index][w] && !has_free) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim  = has_free ? free_way : rr_ptr[req_index];
    rr_next = (WAYS == 1) ? '0 : rr_ptr[req_index] + 1'b1;
  end

  // Valid bits need no reset: the walk entered at reset clears them all
  // before any request can be accepted.
  always_ff @(posedge clk) begin
    if (state == S_FLUSH) begin
      valid[cnt] <= '0;
    end else if (accept) begin
      case (req_op)
        OP_WRITE: valid[req_index][req_way] <= 1'b1;
        OP_INVAL: valid[req_index][req_way] <= 1'b0;
        OP_ALLOC: valid[req_index][victim]  <= 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if (state == S_FLUSH) begin
      rr_ptr[cnt] <= '0;
    end else if (accept && req_op == OP_ALLOC && !has_free) begin
      rr_ptr[req_index] <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_op == OP_WRITE)      tag_mem[req_index][req_way] <= req_tag;
    else if (accept && req_op == OP_ALLOC) tag_mem[req_index][victim]  <= req_tag;
  end

  // Response stage: one cycle after acceptance; fields hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_multi     <= 1'b0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
    end else begin
      resp_valid <= accept && (req_op == OP_LOOKUP || req_op == OP_ALLOC);
      if (accept && req_op == OP_LOOKUP) begin
        resp_hit   <= hit;
        resp_way   <= hit_way;
        resp_multi <= (nmatch > 4'd1);
      end else if (accept && req_op == OP_ALLOC) begin
        resp_way       <= victim;
        resp_evict     <= valid[req_index][victim];
        resp_evict_tag <= valid[req_index][victim] ? tag_mem[req_index][victim] : '0;
      end
    end
  end

endmodule

// File: tb/tb_tag_memory_assoc.sv
// Directed bench for tag_memory_assoc: expected responses are queued when a
// request is driven and compared when the response cycle arrives.
module tb_tag_memory_assoc;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_ALLOC  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_index;
  logic [19:0] req_tag;
  logic [1:0]  req_way;
  logic        flush_req;
  logic        flush_busy;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        resp_multi;
  logic        resp_evict;
  logic [19:0] resp_evict_tag;

  tag_memory_assoc #(.SETS(256), .WAYS(4), .TAG_W(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_index      (req_index),
    .req_tag        (req_tag),
    .req_way        (req_way),
    .flush_req      (flush_req),
    .flush_busy     (flush_busy),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_multi     (resp_multi),
    .resp_evict     (resp_evict),
    .resp_evict_tag (resp_evict_tag)
  );

  typedef struct {
    logic        is_alloc;
    logic        hit;
    logic [1:0]  way;
    logic        multi;
    logic        evict;
    logic [19:0] etag;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_way", {30'd0, resp_way}, {30'd0, e.way});
      if (e.is_alloc) begin
        check("resp_evict", {31'd0, resp_evict}, {31'd0, e.evict});
        check("resp_evict_tag", {12'd0, resp_evict_tag}, {12'd0, e.etag});
      end else begin
        check("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
        check("resp_multi", {31'd0, resp_multi}, {31'd0, e.multi});
      end
    end else begin
      check("no_resp_valid", {31'd0, resp_valid}, 32'd0);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] idx,
                       input logic [19:0] tag, input logic [1:0] way);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_tag   = tag;
    req_way   = way;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    flush_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [7:0] idx, input logic [19:0] tag,
                        input logic hit, input logic [1:0] way, input logic multi);
    exp_t x;
    x.is_alloc = 1'b0; x.hit = hit; x.way = way; x.multi = multi;
    x.evict = 1'b0; x.etag = '0; x.due = cyc + 1;
    q.push_back(x);
    issue(OP_LOOKUP, idx, tag, 2'd0);
  endtask

  task automatic alloc(input logic [7:0] idx, input logic [19:0] tag,
                       input logic [1:0] way, input logic evict, input logic [19:0] etag);
    exp_t x;
    x.is_alloc = 1'b1; x.hit = 1'b0; x.way = way; x.multi = 1'b0;
    x.evict = evict; x.etag = etag; x.due = cyc + 1;
    q.push_back(x);
    issue(OP_ALLOC, idx, tag, 2'd0);
  endtask

  // Releases reset on a falling edge and measures how long flush_busy stays high.
  task automatic walk_after_release(input string name);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (flush_busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 256);
    check("ready_after_walk", {31'd0, req_ready}, 32'd1);
    check("busy_after_walk", {31'd0, flush_busy}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_LOOKUP;
    req_index = '0;
    req_tag   = '0;
    req_way   = '0;
    flush_req = 1'b0;
    #12;
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_flush_busy", {31'd0, flush_busy}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_hit", {31'd0, resp_hit}, 32'd0);
    check("reset_resp_way", {30'd0, resp_way}, 32'd0);
    check("reset_resp_multi", {31'd0, resp_multi}, 32'd0);
    check("reset_resp_evict", {31'd0, resp_evict}, 32'd0);
    check("reset_resp_evict_tag", {12'd0, resp_evict_tag}, 32'd0);
    walk_after_release("walk_len_reset");

    lookup(8'd5, 20'h123, 1'b0, 2'd0, 1'b0);
    alloc(8'd7, 20'hA, 2'd0, 1'b0, 20'h0);
    alloc(8'd7, 20'hB, 2'd1, 1'b0, 20'h0);
    alloc(8'd7, 20'hC, 2'd2, 1'b0, 20'h0);
    alloc(8'd7, 20'hD, 2'd3, 1'b0, 20'h0);
    lookup(8'd7, 20'hC, 1'b1, 2'd2, 1'b0);
    alloc(8'd7, 20'hE, 2'd0, 1'b1, 20'hA);
    alloc(8'd7, 20'hF, 2'd1, 1'b1, 20'hB);
    lookup(8'd7, 20'hA, 1'b0, 2'd0, 1'b0);

    issue(OP_WRITE, 8'd3, 20'h55, 2'd1);
    issue(OP_WRITE, 8'd3, 20'h55, 2'd2);
    lookup(8'd3, 20'h55, 1'b1, 2'd1, 1'b1);
    issue(OP_INVAL, 8'd3, 20'h0, 2'd1);
    lookup(8'd3, 20'h55, 1'b1, 2'd2, 1'b0);

    issue(OP_WRITE, 8'd9, 20'h77, 2'd0);
    lookup(8'd9, 20'h77, 1'b1, 2'd0, 1'b0);

    // Invalid way is filled first without moving the pointer, then it wraps.
    issue(OP_INVAL, 8'd7, 20'h0, 2'd3);
    alloc(8'd7, 20'h10, 2'd3, 1'b0, 20'h0);
    alloc(8'd7, 20'h11, 2'd2, 1'b1, 20'hC);
    alloc(8'd7, 20'h12, 2'd3, 1'b1, 20'h10);
    alloc(8'd7, 20'h13, 2'd0, 1'b1, 20'hE);
    idle(3);

    req_valid = 1'b1;
    req_op    = OP_ALLOC;
    req_index = 8'd7;
    req_tag   = 20'h99;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    req_valid = 1'b0;
    check("flush_busy_started", {31'd0, flush_busy}, 32'd1);
    check("flush_ready_low", {31'd0, req_ready}, 32'd0);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midwalk_reset_busy", {31'd0, flush_busy}, 32'd1);
    check("midwalk_reset_resp_way", {30'd0, resp_way}, 32'd0);
    walk_after_release("walk_len_midwalk_reset");

    lookup(8'd7, 20'h11, 1'b0, 2'd0, 1'b0);
    lookup(8'd9, 20'h77, 1'b0, 2'd0, 1'b0);
    lookup(8'd3, 20'h55, 1'b0, 2'd0, 1'b0);
    alloc(8'd7, 20'h20, 2'd0, 1'b0, 20'h0);
    idle(3);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
